// File: rtl/aes_pkg.sv
// Shared AES decrypt helpers: round count, FSM states, InvSubBytes and InvMixColumns.
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} aes_state_t;

    // Row-major inverse S-box; element 0 is the most significant byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(b[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] b);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[32*j +: 32] = inv_mix_column(b[32*j +: 32]);
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_shift_rows.sv
// AES InvShiftRows byte permutation on a column-major 128-bit block.
// Latency: 0 cycles (pure wiring).
// Backpressure: none, combinational.
module aes_inv_shift_rows (
    input  logic [127:0] i_block,
    output logic [127:0] o_block
);

    // Row r moves right by r columns: out column j takes in column (j - r) mod 4.
    for (genvar j = 0; j < 4; j++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_block[127-32*j-8*r -: 8] = i_block[127-32*((j-r+4)%4)-8*r -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor, one inverse round per cycle (two with AES_INV_CIPHER_SBOX_REG_EN).
// Latency: accept to o_valid 11 cycles (21 with the macro); new block every 12 (22).
// Backpressure: o_valid/o_block hold until i_ready; o_ready only in IDLE, busy i_valid ignored.
module aes_inv_cipher
    import aes_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_block,
    output logic [3:0]   o_rk_idx,
    input  logic [127:0] i_rk,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_block
);

    aes_state_t   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_reg, state_reg_d;
    logic [127:0] oblk_d;
    logic [127:0] isr, isb, rnd_in;
    logic         step;

    aes_inv_shift_rows u_inv_shift_rows (
        .i_block (state_reg),
        .o_block (isr)
    );

    assign isb = inv_sub_bytes(isr);

`ifdef AES_INV_CIPHER_SBOX_REG_EN
    // Phase 0 registers the S-box result, phase 1 finishes the round from that register.
    logic         phase_q, phase_d;
    logic [127:0] pipe_q, pipe_d;
    assign step   = phase_q;
    assign rnd_in = pipe_q;
`else
    assign step   = 1'b1;
    assign rnd_in = isb;
`endif

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        state_reg_d = state_reg;
        oblk_d      = o_block;
        o_ready     = (state_q == ST_IDLE);
        o_valid     = (state_q == ST_DONE);
        o_rk_idx    = (state_q == ST_IDLE) ? 4'(AES_NR) : rnd_q;
`ifdef AES_INV_CIPHER_SBOX_REG_EN
        phase_d     = phase_q;
        pipe_d      = pipe_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_reg_d = i_block ^ i_rk;
                    rnd_d       = 4'(AES_NR - 1);
                    state_d     = ST_ROUND;
                end
            end
            ST_ROUND: begin
`ifdef AES_INV_CIPHER_SBOX_REG_EN
                phase_d = ~phase_q;
                if (!phase_q) pipe_d = isb;
`endif
                if (step) begin
                    if (rnd_q != 4'd0) begin
                        state_reg_d = inv_mix_columns(rnd_in ^ i_rk);
                        rnd_d       = rnd_q - 4'd1;
                    end else begin
                        oblk_d  = rnd_in ^ i_rk;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            rnd_q     <= '0;
            state_reg <= '0;
            o_block   <= '0;
`ifdef AES_INV_CIPHER_SBOX_REG_EN
            phase_q   <= 1'b0;
            pipe_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            state_reg <= state_reg_d;
            o_block   <= oblk_d;
`ifdef AES_INV_CIPHER_SBOX_REG_EN
            phase_q   <= phase_d;
            pipe_q    <= pipe_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: plaintexts are encrypted by an in-bench AES model and fed as ciphertext.
// Latency: model expects o_valid 11 cycles after accept (21 with AES_INV_CIPHER_SBOX_REG_EN).
// Backpressure: i_ready is driven manually or randomly; the model follows the same handshake.
module tb_aes_inv_cipher;

`ifdef AES_INV_CIPHER_SBOX_REG_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 1;
`endif
    localparam int LAT    = 1 + 10 * HOLD;
    localparam int PERIOD = LAT + 1;

    typedef logic [10:0][127:0] ks_t;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         dut_ready;
    logic [127:0] in_block;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    logic         rdy_manual = 1'b1;
    logic         rdy_rand   = 1'b1;
    logic         rand_rdy   = 1'b0;
    ks_t          pend_ks    = '0;
    ks_t          act_ks     = '0;
    logic [127:0] cur_pt     = '0;
    logic [7:0]   sb [256];

    int cyc       = 0;
    int m_st      = 0;   // 0 idle, 1 busy, 2 done
    int m_cnt     = 0;
    int m_acc_cyc = 0;
    int m_acc_n   = 0;
    bit m_live    = 1'b0;
    logic [127:0] m_exp = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    aes_inv_cipher dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (in_valid),
        .o_ready  (dut_ready),
        .i_block  (in_block),
        .o_rk_idx (rk_idx),
        .i_rk     (rk),
        .o_valid  (out_valid),
        .i_ready  (out_ready),
        .o_block  (out_block)
    );

    // Key store: the pending key serves the accept cycle, the in-flight key serves the rounds.
    always_comb begin
        rk = '0;
        if (rk_idx <= 4'd10) rk = dut_ready ? pend_ks[rk_idx] : act_ks[rk_idx];
    end

    assign out_ready = rand_rdy ? rdy_rand : rdy_manual;

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic ks_t expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        ks_t         ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input ks_t ks);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] v;
        v = pt ^ ks[0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int k = 0; k < 16; k++) s[k] = sb[v[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
                    s[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k];
            v = v ^ ks[rd];
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Transaction-level model: idle -> busy for LAT-1 cycles -> done until i_ready.
    always @(posedge clk) begin
        if (rst) begin
            m_st   = 0;
            m_cnt  = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            case (m_st)
                0: if (in_valid) begin
                    m_st      = 1;
                    m_cnt     = 1;
                    m_exp     = cur_pt;
                    act_ks    = pend_ks;
                    m_acc_cyc = cyc;
                    m_acc_n++;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == LAT) m_st = 2;
                end
                default: if (out_ready) m_st = 0;
            endcase
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("o_ready", 128'(dut_ready), 128'(m_st == 0));
            chk("o_valid", 128'(out_valid), 128'(m_st == 2));
            if (m_st != 2) chk("o_rk_idx", 128'(rk_idx), 128'(m_st == 0 ? 10 : 9 - (m_cnt - 1) / HOLD));
            else chk("o_block", out_block, m_exp);
        end
    end

    task automatic present(input logic [127:0] key, input logic [127:0] pt);
        pend_ks  = expand(key);
        cur_pt   = pt;
        in_block = encrypt(pt, pend_ks);
        in_valid = 1'b1;
    endtask

    task automatic wait_acc(input int prev);
        int n;
        n = 0;
        while (m_acc_n == prev && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 128'(m_acc_n != prev), 128'(1));
    endtask

    task automatic send(input logic [127:0] key, input logic [127:0] pt);
        int p;
        p = m_acc_n;
        present(key, pt);
        wait_acc(p);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        int n;
        n = 0;
        c = -1;
        while (n < 300) begin
            @(negedge clk);
            if (out_valid) begin
                c = cyc;
                break;
            end
            n++;
        end
        chk("valid_timeout", 128'(c >= 0), 128'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dut_ready && m_st == 0) && n < 300);
        chk("idle_timeout", 128'(dut_ready), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c1, c2, seen;
        int seq [32];
        ks_t ks;
        logic [7:0] inv;
        logic [7:0] b;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_block = '0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int k = 0; k < 254; k++) inv = gm(inv, 8'(x));
            b = inv;
            sb[x] = b ^ rl(b) ^ rl(rl(b)) ^ rl(rl(rl(b))) ^ rl(rl(rl(rl(b)))) ^ 8'h63;
        end

        // Pin the reference model on published vectors.
        ks = expand(KEY_B);
        chk("model_rk10", ks[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_enc_b", encrypt(PT_B, ks), CT_B);
        chk("model_enc_c", encrypt(PT_C, expand(KEY_C)), CT_C);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 128'(dut_ready), 128'(1));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_block", out_block, 128'h0);
        chk("rst_rk_idx", 128'(rk_idx), 128'(10));

        // Known-answer with latency.
        @(posedge clk);
        #1 send(KEY_B, PT_B);
        wait_valid(c1);
        chk("latency_b", 128'(c1 - m_acc_cyc), 128'(LAT));
        chk("pt_b", out_block, 128'h3243f6a8885a308d313198a2e0370734);
        wait_idle();

        // Round-key index sequence.
        @(posedge clk);
        #1 send(KEY_C, PT_C);
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            seq[k] = int'(rk_idx);
        end
        c1 = 1;
        for (int r = 9; r >= 0; r--)
            for (int h = 0; h < HOLD; h++) begin
                chk("rk_seq", 128'(seq[c1]), 128'(r));
                c1++;
            end
        wait_valid(c1);
        chk("pt_c", out_block, 128'h00112233445566778899aabbccddeeff);
        wait_idle();

        // Output backpressure.
        @(posedge clk);
        #1 rdy_manual = 1'b0;
        send(KEY_B, PT_B);
        wait_valid(c1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_ready", 128'(dut_ready), 128'(0));
            chk("bp_block", out_block, PT_B);
        end
        @(posedge clk);
        #1 rdy_manual = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 128'(dut_ready), 128'(1));
        chk("bp_release_valid", 128'(out_valid), 128'(0));

        // Back-to-back with i_valid held high; second block waits out the first.
        @(posedge clk);
        #1;
        c2 = m_acc_n;
        present(KEY_B, PT_B);
        wait_acc(c2);
        present(KEY_C, PT_C);
        wait_valid(c1);
        chk("b2b_first", out_block, PT_B);
        @(posedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(c2);
        chk("b2b_second", out_block, PT_C);
        chk("b2b_period", 128'(c2 - c1), 128'(PERIOD));
        wait_idle();

        // Reset in cycle 5 of an operation.
        @(posedge clk);
        #1 send(KEY_B, PT_B);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 128'(dut_ready), 128'(1));
        chk("midrst_valid", 128'(out_valid), 128'(0));
        chk("midrst_block", out_block, 128'h0);
        chk("midrst_rk_idx", 128'(rk_idx), 128'(10));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("midrst_no_valid", 128'(seen), 128'(0));
        @(posedge clk);
        #1 send(KEY_C, PT_C);
        wait_valid(c1);
        chk("midrst_next_pt", out_block, PT_C);
        wait_idle();

        // Random keys/plaintexts, random i_ready stalls, junk i_valid while busy.
        rand_rdy = 1'b1;
        for (int it = 0; it < 15; it++) begin
            @(posedge clk);
            #1 send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            in_block = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
